// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div, HI/LO ownership,
// mfhi/mflo reads and mthi/mtlo writes.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDU_start,
    input  logic [3:0]  E_MDU_op,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    output logic        E_MDU_busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_MDU_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q, tmp_hi_q, tmp_lo_q;
    logic               dz_q;

    logic               is_mdu_op, is_mult;
    logic [63:0]        prod;
    logic [31:0]        a_mag, b_mag, divisor, q_mag, r_mag;
    logic [31:0]        res_hi, res_lo;
    logic               res_dz;

    assign is_mdu_op = (E_MDU_op >= OP_MULT) && (E_MDU_op <= OP_DIVU);
    assign is_mult   = (E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU);

    // Result of the op presented this cycle; only latched on a launch edge.
    // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod    = 64'd0;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_dz  = 1'b0;
        a_mag   = E_MDU_A;
        b_mag   = E_MDU_B;
        if (E_MDU_op == OP_DIV) begin
            a_mag = E_MDU_A[31] ? 32'(32'd0 - E_MDU_A) : E_MDU_A;
            b_mag = E_MDU_B[31] ? 32'(32'd0 - E_MDU_B) : E_MDU_B;
        end
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        case (E_MDU_op)
            OP_MULT: begin
                prod   = {{32{E_MDU_A[31]}}, E_MDU_A} * {{32{E_MDU_B[31]}}, E_MDU_B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_MULTU: begin
                prod   = {32'd0, E_MDU_A} * {32'd0, E_MDU_B};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV: begin
                res_dz = (E_MDU_B == 32'd0);
                res_lo = (E_MDU_A[31] ^ E_MDU_B[31]) ? 32'(32'd0 - q_mag) : q_mag;
                res_hi = E_MDU_A[31] ? 32'(32'd0 - r_mag) : r_mag;
            end
            OP_DIVU: begin
                res_dz = (E_MDU_B == 32'd0);
                res_lo = q_mag;
                res_hi = r_mag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (E_MDU_start && is_mdu_op) begin
                        tmp_hi_q <= res_hi;
                        tmp_lo_q <= res_lo;
                        dz_q     <= res_dz;
                        cnt_q    <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_q  <= BUSY;
                    end else if (!E_MDU_start && E_MDU_op == OP_MTHI) begin
                        hi_q <= E_MDU_A;
                    end else if (!E_MDU_start && E_MDU_op == OP_MTLO) begin
                        lo_q <= E_MDU_A;
                    end
                end
                BUSY: begin
                    // Last busy cycle commits; a divide by zero leaves HI/LO alone.
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (!dz_q) begin
                            hi_q <= tmp_hi_q;
                            lo_q <= tmp_lo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign E_MDU_busy = (state_q == BUSY);
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign E_MDU_out  = (E_MDU_op == OP_MFHI) ? hi_q :
                        (E_MDU_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and owns the HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Drives the busy indication that the hazard control unit combines with start to stall MDU-class instructions in D.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10, number of busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- E_MDU_start  input  1  one-cycle pulse; launches the mult/div selected by E_MDU_op.
- E_MDU_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none.
- E_MDU_A  input  32  rs operand (forwarded value).
- E_MDU_B  input  32  rt operand (forwarded value).
- E_MDU_busy  output  1  high while a mult/div is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- E_MDU_out  output  32  read result: HI when op=5, LO when op=6, else 0; combinational.

Behaviour:
- Reset (clk edge with reset=1):
  - busy=0, counter=0, HI=0, LO=0, temporary result registers=0.
  - Reset wins over every other input on that edge.
  - Reset mid-operation aborts the operation; HI/LO stay 0 and are never written with the aborted result.
- State: IDLE / BUSY, with a down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
- Launch:
  - Condition: edge in IDLE with E_MDU_start=1 and op in 1..4.
  - Latch the result into tmp_hi/tmp_lo, computed from E_MDU_A/E_MDU_B on that edge.
  - Load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Enter BUSY.
- Timing: if start is sampled at edge T, E_MDU_busy=1 for exactly N cycles after T, where N is the loaded count.
  - On the edge ending the Nth busy cycle: HI<=tmp_hi, LO<=tmp_lo, busy<=0, return to IDLE.
  - Back-to-back: a new start may be accepted on the first IDLE edge after completion.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), 64-bit.
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): the full busy period still elapses; HI and LO keep their previous values.
- mthi/mtlo (ops 7, 8): in IDLE with start=0, HI<=A or LO<=A on the edge, single cycle, busy never asserted.
- Ignored inputs, state unchanged:
  - E_MDU_start while BUSY.
  - E_MDU_start with op outside 1..4.
  - mthi/mtlo while BUSY; the HCU guarantees these never occur, and the block must still tolerate them.
- Reads: mfhi/mflo return HI/LO combinationally. During BUSY they return the old committed values; the HCU stall prevents such reads from issuing.
- Operands: E_MDU_A/B are sampled only on the launch edge. Changes during BUSY have no effect.

Test Plan:
- Reset, then mult with A=0xFFFFFFFE (−2), B=3, start pulse at edge T -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- multu with A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (−7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=0 -> 10 busy cycles; HI/LO unchanged.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on the next cycle, then mfhi/mflo -> E_MDU_out=0x12345678 then 0x9ABCDEF0; busy stays 0 throughout.
- Start div; on busy cycle 4 pulse start with mult and drive op=7 with A=0xDEAD -> both ignored; div result commits after the 10th busy cycle; HI is not 0xDEAD.
- Start mult; assert reset on busy cycle 3 -> next cycle busy=0, HI=LO=0; no write occurs at the original completion time.
